// File: rtl/wptr_full_pkt.sv
// Write-domain pointer/flag generator for the async FIFO: packet commit/discard,
// registered fill level, almost-full, sticky overflow, single-step Gray publish.
module wptr_full_pkt #(
  parameter int unsigned ADDR_SIZE = 5,
  parameter bit          PKT_MODE  = 1'b1,
  parameter int unsigned AF_LEVEL  = 2**ADDR_SIZE - 4
) (
  input  logic                 i_wclk,
  input  logic                 i_wrst,
  input  logic                 i_winc,
  input  logic                 i_wcommit,
  input  logic                 i_wdiscard,
  input  logic                 i_wovf_clr,
  input  logic [ADDR_SIZE:0]   i_wq2_rptr,
  output logic [ADDR_SIZE-1:0] o_waddr,
  output logic                 o_wwen,
  output logic [ADDR_SIZE:0]   o_wptr,
  output logic                 o_wfull,
  output logic                 o_walmost_full,
  output logic [ADDR_SIZE:0]   o_wlevel,
  output logic                 o_wovf,
  output logic                 o_wpkt_drop
);

  localparam int unsigned PW    = ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 2**ADDR_SIZE;

  logic [PW-1:0] r_wbin, r_cbin, r_pbin, r_wptr, r_wlevel;
  logic          r_wfull, r_walmost_full, r_wovf, r_wpkt_drop, r_pkt_bad;

  logic [PW-1:0] w_rbin, w_wbin_inc, w_wbin_next, w_cbin_next, w_pbin_next, w_diff;
  logic          w_wwen, w_discard, w_commit, w_ovf_set, w_pkt_bad_next, w_wovf_next;

  // Gray-to-binary of the synchronised read pointer (XOR prefix from the MSB)
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_rbin[i] = ^(i_wq2_rptr >> i);
    end
  end

  // Next-state logic; discard wins over commit and over a same-cycle write
  always_comb begin
    w_wwen         = i_winc & ~r_wfull;
    w_wbin_inc     = r_wbin + PW'(w_wwen);
    w_discard      = PKT_MODE & (i_wdiscard | (i_wcommit & r_pkt_bad));
    w_commit       = PKT_MODE & i_wcommit & ~r_pkt_bad & ~i_wdiscard;
    w_wbin_next    = w_discard ? r_cbin : w_wbin_inc;
    w_cbin_next    = (!PKT_MODE || w_commit) ? w_wbin_inc : r_cbin;
    w_pbin_next    = (r_pbin != r_cbin) ? (r_pbin + PW'(1)) : r_pbin;
    w_diff         = w_wbin_next - w_rbin;
    w_ovf_set      = i_winc & r_wfull;
    w_pkt_bad_next = PKT_MODE & ~w_discard & (r_pkt_bad | w_ovf_set);
    w_wovf_next    = w_ovf_set | (r_wovf & ~i_wovf_clr);
  end

  always_ff @(posedge i_wclk or posedge i_wrst) begin
    if (i_wrst) begin
      r_wbin         <= '0;
      r_cbin         <= '0;
      r_pbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wovf         <= 1'b0;
      r_wpkt_drop    <= 1'b0;
      r_pkt_bad      <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_cbin         <= w_cbin_next;
      r_pbin         <= w_pbin_next;
      r_wptr         <= (w_pbin_next >> 1) ^ w_pbin_next;
      r_wlevel       <= w_diff;
      r_wfull        <= (w_diff == PW'(DEPTH));
      r_walmost_full <= (w_diff >= PW'(AF_LEVEL));
      r_wovf         <= w_wovf_next;
      r_wpkt_drop    <= w_discard;
      r_pkt_bad      <= w_pkt_bad_next;
    end
  end

  assign o_waddr        = r_wbin[ADDR_SIZE-1:0];
  assign o_wwen         = w_wwen;
  assign o_wptr         = r_wptr;
  assign o_wfull        = r_wfull;
  assign o_walmost_full = r_walmost_full;
  assign o_wlevel       = r_wlevel;
  assign o_wovf         = r_wovf;
  assign o_wpkt_drop    = r_wpkt_drop;

endmodule

// File: tb/tb_wptr_full_pkt.sv
// Directed bench for wptr_full_pkt: a streaming instance (PKT_MODE=0) and a
// packet instance (PKT_MODE=1), both ADDR_SIZE=3, AF_LEVEL=6, sharing stimulus.
module tb_wptr_full_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc, wcommit, wdiscard, wovf_clr;
  logic [3:0] rptr;

  logic [2:0] waddr0, waddr1;
  logic       wwen0, wwen1;
  logic [3:0] wptr0, wptr1, wlevel0, wlevel1;
  logic       wfull0, wfull1, waf0, waf1, wovf0, wovf1, drop0, drop1;

  int n_chk = 0;
  int n_err = 0;
  int g [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

  always #5 clk = ~clk;

  wptr_full_pkt #(.ADDR_SIZE(3), .PKT_MODE(1'b0), .AF_LEVEL(6)) u_dut0 (
    .i_wclk(clk), .i_wrst(rst), .i_winc(winc), .i_wcommit(wcommit),
    .i_wdiscard(wdiscard), .i_wovf_clr(wovf_clr), .i_wq2_rptr(rptr),
    .o_waddr(waddr0), .o_wwen(wwen0), .o_wptr(wptr0), .o_wfull(wfull0),
    .o_walmost_full(waf0), .o_wlevel(wlevel0), .o_wovf(wovf0), .o_wpkt_drop(drop0)
  );

  wptr_full_pkt #(.ADDR_SIZE(3), .PKT_MODE(1'b1), .AF_LEVEL(6)) u_dut1 (
    .i_wclk(clk), .i_wrst(rst), .i_winc(winc), .i_wcommit(wcommit),
    .i_wdiscard(wdiscard), .i_wovf_clr(wovf_clr), .i_wq2_rptr(rptr),
    .o_waddr(waddr1), .o_wwen(wwen1), .o_wptr(wptr1), .o_wfull(wfull1),
    .o_walmost_full(waf1), .o_wlevel(wlevel1), .o_wovf(wovf1), .o_wpkt_drop(drop1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    winc = 1'b0; wcommit = 1'b0; wdiscard = 1'b0; wovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rptr = '0;
    rst  = 1'b1;
    #1;
    check_eq("rst_wptr",   {wptr1, wptr0}, 0);
    check_eq("rst_level",  {wlevel1, wlevel0}, 0);
    check_eq("rst_flags",  {wfull1, waf1, wovf1, drop1, wfull0, waf0, wovf0, drop0}, 0);
    check_eq("rst_waddr",  {waddr1, waddr0}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // streaming: 9 writes into an 8-deep FIFO
    do_reset();
    for (int k = 0; k < 9; k++) begin
      check_eq("s_wptr",  wptr0, g[(k == 0) ? 0 : k - 1]);
      check_eq("s_level", wlevel0, k);
      check_eq("s_full",  wfull0, (k == 8));
      winc = 1'b1;
      #1;
      check_eq("s_wwen", wwen0, (k < 8));
      if (k < 8) check_eq("s_waddr", waddr0, k);
      tick();
    end
    idle();
    check_eq("s_wptr_end", wptr0, 12);
    check_eq("s_full_end", wfull0, 1);
    check_eq("s_ovf",      wovf0, 1);
    check_eq("s_lvl_end",  wlevel0, 8);
    winc = 1'b1; wovf_clr = 1'b1;
    tick();
    check_eq("s_ovf_setwins", wovf0, 1);
    winc = 1'b0;
    tick();
    check_eq("s_ovf_clr", wovf0, 0);
    idle();

    // packet: 5 words then commit, published one Gray step per cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      check_eq("p_level", wlevel1, k);
      check_eq("p_wptr",  wptr1, 0);
      winc = 1'b1;
      #1;
      check_eq("p_waddr", waddr1, k);
      tick();
    end
    winc = 1'b0; wcommit = 1'b1;
    check_eq("p_level5", wlevel1, 5);
    check_eq("p_wptr0",  wptr1, 0);
    tick();
    wcommit = 1'b0;
    check_eq("p_wptr_commit", wptr1, 0);
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq("p_pub", wptr1, g[j]);
    end
    tick();
    check_eq("p_pub_hold", wptr1, 7);
    check_eq("p_lvl_hold", wlevel1, 5);

    // packet: 3 words then discard with a concurrent write
    do_reset();
    for (int k = 0; k < 3; k++) begin
      winc = 1'b1;
      tick();
    end
    check_eq("d_level3", wlevel1, 3);
    winc = 1'b1; wdiscard = 1'b1;
    tick();
    idle();
    check_eq("d_drop",  drop1, 1);
    check_eq("d_level", wlevel1, 0);
    check_eq("d_wptr",  wptr1, 0);
    tick();
    check_eq("d_drop_pulse", drop1, 0);
    winc = 1'b1;
    #1;
    check_eq("d_waddr", waddr1, 0);
    tick();
    idle();
    check_eq("d_wptr_still", wptr1, 0);

    // overflow inside a packet turns the commit into a discard
    do_reset();
    for (int k = 0; k < 8; k++) begin
      winc = 1'b1; wcommit = (k == 1);
      tick();
    end
    wcommit = 1'b0;
    check_eq("o_full", wfull1, 1);
    check_eq("o_wptr_pre", wptr1, 3);
    winc = 1'b1;
    #1;
    check_eq("o_wwen", wwen1, 0);
    tick();
    check_eq("o_ovf", wovf1, 1);
    winc = 1'b0; wcommit = 1'b1;
    tick();
    idle();
    check_eq("o_drop",  drop1, 1);
    check_eq("o_level", wlevel1, 2);
    check_eq("o_wptr",  wptr1, 3);
    check_eq("o_nfull", wfull1, 0);

    // almost-full threshold and freed space
    do_reset();
    for (int k = 0; k < 6; k++) begin
      check_eq("a_af_low", waf0, 0);
      winc = 1'b1;
      tick();
    end
    winc = 1'b0;
    check_eq("a_af_high", waf0, 1);
    check_eq("a_level6",  wlevel0, 6);
    rptr = 4'd1;
    tick();
    check_eq("a_af_fall", waf0, 0);
    check_eq("a_level5",  wlevel0, 5);

    // asynchronous reset mid-publish (cbin=6, pbin=3)
    do_reset();
    for (int k = 0; k < 6; k++) begin
      winc = 1'b1; wcommit = (k == 5);
      tick();
    end
    idle();
    for (int j = 0; j < 3; j++) tick();
    check_eq("r_wptr_mid", wptr1, 2);
    check_eq("r_lvl_mid",  wlevel1, 6);
    #2;
    rst = 1'b1;
    #1;
    check_eq("r_wptr",  wptr1, 0);
    check_eq("r_level", wlevel1, 0);
    check_eq("r_waddr", waddr1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    winc = 1'b1;
    #1;
    check_eq("r_waddr_after", waddr1, 0);
    check_eq("r_wwen_after",  wwen1, 1);
    tick();
    idle();
    check_eq("r_level1", wlevel1, 1);
    tick();
    check_eq("r_wptr_after", wptr1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
